vdp_vram_arbiter: RTL and testbench

VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

---
 rtl/vdp_vram_arbiter_if.sv | 32 +++
 rtl/vdp_vram_arbiter.sv | 102 ++++++++++
 tb/tb_vdp_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its requesters / VRAM array.
// Latency: none (wires only).
// Backpressure: carried by spr_ack, cpu_ack and cpu_busy.
interface vdp_vram_arbiter_if;
    logic        active;
    logic [2:0]  slot;
    logic [13:0] bg_a;
    logic        spr_req;
    logic [13:0] spr_a;
    logic        spr_ack;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_a;
    logic [7:0]  cpu_wd;
    logic        cpu_ack;
    logic [7:0]  cpu_rd;
    logic        cpu_busy;
    logic [13:0] vram_a;
    logic        vram_we;
    logic [7:0]  vram_wd;
    logic [7:0]  vram_d;

    modport slave (
        input  active, slot, bg_a, spr_req, spr_a, cpu_req, cpu_we, cpu_a, cpu_wd, vram_d,
        output spr_ack, cpu_ack, cpu_rd, cpu_busy, vram_a, vram_we, vram_wd
    );

    modport master (
        output active, slot, bg_a, spr_req, spr_a, cpu_req, cpu_we, cpu_a, cpu_wd, vram_d,
        input  spr_ack, cpu_ack, cpu_rd, cpu_busy, vram_a, vram_we, vram_wd
    );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: background fetch, sprite reads and CPU accesses.
// Latency: address registered at grant edge, data/ack one cycle after that.
// Backpressure: sprite holds spr_req until spr_ack; CPU waits while cpu_busy.
module vdp_vram_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    vdp_vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_ISSUED} cpu_state_t;
    typedef enum logic [1:0] {GNT_BG, GNT_SPR, GNT_CPU} gnt_t;

    cpu_state_t  state_q, state_d;
    gnt_t        gnt;
    logic [13:0] cpu_a_q;
    logic        cpu_we_q;
    logic [7:0]  cpu_wd_q;
    logic        spr_inflight;
    logic        spr_issued;
    logic        rr_cpu;
    logic        ack_rd;
    logic        spr_pend;
    logic        cpu_pend;

    assign spr_pend = bus.spr_req && !spr_inflight;
    assign cpu_pend = (state_q == CPU_PEND);

    // Active display: only slots 2 and 7 are free for SPR/CPU; blanking is round-robin.
    always_comb begin
        gnt = GNT_BG;
        if (bus.active) begin
            if (bus.slot == 3'd2) begin
                if (spr_pend)      gnt = GNT_SPR;
                else if (cpu_pend) gnt = GNT_CPU;
            end else if (bus.slot == 3'd7) begin
                if (cpu_pend)      gnt = GNT_CPU;
                else if (spr_pend) gnt = GNT_SPR;
            end
        end else if (cpu_pend && (rr_cpu || !spr_pend)) begin
            gnt = GNT_CPU;
        end else if (spr_pend) begin
            gnt = GNT_SPR;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_IDLE:   if (bus.cpu_req) state_d = CPU_PEND;
            CPU_PEND:   if (gnt == GNT_CPU) state_d = CPU_ISSUED;
            default:    state_d = CPU_IDLE;
        endcase
    end

    // The ack cycle counts as busy so back-to-back transactions show no gap.
    assign bus.cpu_busy = (state_q != CPU_IDLE) || bus.cpu_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CPU_IDLE;
            cpu_a_q      <= '0;
            cpu_we_q     <= 1'b0;
            cpu_wd_q     <= '0;
            spr_inflight <= 1'b0;
            spr_issued   <= 1'b0;
            rr_cpu       <= 1'b1;
            ack_rd       <= 1'b0;
            bus.vram_a   <= '0;
            bus.vram_we  <= 1'b0;
            bus.vram_wd  <= '0;
            bus.spr_ack  <= 1'b0;
            bus.cpu_ack  <= 1'b0;
            bus.cpu_rd   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CPU_IDLE && bus.cpu_req) begin
                cpu_a_q  <= bus.cpu_a;
                cpu_we_q <= bus.cpu_we;
                cpu_wd_q <= bus.cpu_wd;
            end

            case (gnt)
                GNT_CPU: bus.vram_a <= cpu_a_q;
                GNT_SPR: bus.vram_a <= bus.spr_a;
                default: bus.vram_a <= bus.bg_a;
            endcase
            bus.vram_we <= (gnt == GNT_CPU) && cpu_we_q;
            bus.vram_wd <= ((gnt == GNT_CPU) && cpu_we_q) ? cpu_wd_q : 8'h00;

            spr_issued  <= (gnt == GNT_SPR);
            bus.spr_ack <= spr_issued;
            if (gnt == GNT_SPR)   spr_inflight <= 1'b1;
            else if (bus.spr_ack) spr_inflight <= 1'b0;

            if (!bus.active && gnt != GNT_BG) rr_cpu <= !rr_cpu;

            // Read data arrives with the ack; capture it at the end of that cycle.
            bus.cpu_ack <= (state_q == CPU_ISSUED);
            ack_rd      <= (state_q == CPU_ISSUED) && !cpu_we_q;
            if (bus.cpu_ack && ack_rd) bus.cpu_rd <= bus.vram_d;
        end
    end
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter: vector table plus multi-cycle sequences.
module tb_vdp_vram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    vdp_vram_arbiter_if bus();

    vdp_vram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mdl(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    // VRAM read model: data for the address presented last cycle.
    always @(posedge clk) bus.vram_d <= mdl(bus.vram_a);

    typedef struct {
        logic        active;
        logic [2:0]  slot;
        logic [13:0] bg_a;
        logic        cpu_req;
        logic        cpu_we;
        logic [13:0] cpu_a;
        logic [7:0]  cpu_wd;
        logic [13:0] e_a;
        logic        e_we;
        logic [7:0]  e_wd;
        logic        e_ack;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic act, input logic [2:0] sl, input logic [13:0] bg,
                                input logic rq, input logic we, input logic [13:0] a,
                                input logic [7:0] wd, input logic [13:0] ea, input logic ewe,
                                input logic [7:0] ewd, input logic eack, input logic ebusy);
        vec_t v;
        v.active = act; v.slot = sl; v.bg_a = bg; v.cpu_req = rq; v.cpu_we = we;
        v.cpu_a = a; v.cpu_wd = wd; v.e_a = ea; v.e_we = ewe; v.e_wd = ewd;
        v.e_ack = eack; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.active = 1'b0; bus.slot = 3'd0; bus.bg_a = '0;
        bus.spr_req = 1'b0; bus.spr_a = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_wd = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vram_a"},   bus.vram_a,   0);
        chk({tag, "_vram_we"},  bus.vram_we,  0);
        chk({tag, "_vram_wd"},  bus.vram_wd,  0);
        chk({tag, "_spr_ack"},  bus.spr_ack,  0);
        chk({tag, "_cpu_ack"},  bus.cpu_ack,  0);
        chk({tag, "_cpu_rd"},   bus.cpu_rd,   0);
        chk({tag, "_cpu_busy"}, bus.cpu_busy, 0);
    endtask

    vec_t tbl[16];
    logic [13:0] exp_g[7];

    initial begin
        int n, ng, spr_g, spr_k, cpu_k, cyc;
        logic prev_ack, prev_spr_ack, spr_hold;

        bus.vram_d = '0;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Active display: background every slot, one CPU write raised at slot 3.
        tbl[0]  = mk(1, 0, 14'h0100, 0, 0, 14'h0000, 8'h00, 14'h0100, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 14'h0101, 0, 0, 14'h0000, 8'h00, 14'h0101, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 2, 14'h0102, 0, 0, 14'h0000, 8'h00, 14'h0102, 0, 8'h00, 0, 0);
        tbl[3]  = mk(1, 3, 14'h0103, 1, 1, 14'h1234, 8'hA5, 14'h0103, 0, 8'h00, 0, 1);
        tbl[4]  = mk(1, 4, 14'h0104, 0, 0, 14'h0000, 8'h00, 14'h0104, 0, 8'h00, 0, 1);
        tbl[5]  = mk(1, 5, 14'h0105, 0, 0, 14'h0000, 8'h00, 14'h0105, 0, 8'h00, 0, 1);
        tbl[6]  = mk(1, 6, 14'h0106, 0, 0, 14'h0000, 8'h00, 14'h0106, 0, 8'h00, 0, 1);
        tbl[7]  = mk(1, 7, 14'h0107, 0, 0, 14'h0000, 8'h00, 14'h1234, 1, 8'hA5, 0, 1);
        tbl[8]  = mk(1, 0, 14'h0108, 0, 0, 14'h0000, 8'h00, 14'h0108, 0, 8'h00, 1, 1);
        tbl[9]  = mk(1, 1, 14'h0109, 0, 0, 14'h0000, 8'h00, 14'h0109, 0, 8'h00, 0, 0);
        tbl[10] = mk(1, 2, 14'h010A, 0, 0, 14'h0000, 8'h00, 14'h010A, 0, 8'h00, 0, 0);
        tbl[11] = mk(1, 3, 14'h010B, 0, 0, 14'h0000, 8'h00, 14'h010B, 0, 8'h00, 0, 0);
        tbl[12] = mk(1, 4, 14'h010C, 0, 0, 14'h0000, 8'h00, 14'h010C, 0, 8'h00, 0, 0);
        tbl[13] = mk(1, 5, 14'h010D, 0, 0, 14'h0000, 8'h00, 14'h010D, 0, 8'h00, 0, 0);
        tbl[14] = mk(1, 6, 14'h010E, 0, 0, 14'h0000, 8'h00, 14'h010E, 0, 8'h00, 0, 0);
        tbl[15] = mk(1, 7, 14'h010F, 0, 0, 14'h0000, 8'h00, 14'h010F, 0, 8'h00, 0, 0);

        for (int i = 0; i < 16; i++) begin
            bus.active  = tbl[i].active;
            bus.slot    = tbl[i].slot;
            bus.bg_a    = tbl[i].bg_a;
            bus.cpu_req = tbl[i].cpu_req;
            bus.cpu_we  = tbl[i].cpu_we;
            bus.cpu_a   = tbl[i].cpu_a;
            bus.cpu_wd  = tbl[i].cpu_wd;
            tick();
            chk($sformatf("vec%0d_vram_a", i),   bus.vram_a,   tbl[i].e_a);
            chk($sformatf("vec%0d_vram_we", i),  bus.vram_we,  tbl[i].e_we);
            chk($sformatf("vec%0d_vram_wd", i),  bus.vram_wd,  tbl[i].e_wd);
            chk($sformatf("vec%0d_cpu_ack", i),  bus.cpu_ack,  tbl[i].e_ack);
            chk($sformatf("vec%0d_cpu_busy", i), bus.cpu_busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_cpu_rd", i),   bus.cpu_rd,   0);
        end

        // Sprite and CPU read contend: SPR takes slot 2, CPU takes slot 7.
        do_reset();
        bus.active = 1'b1; bus.spr_a = 14'h2000; bus.cpu_we = 1'b0; bus.cpu_a = 14'h0ABC;
        spr_hold = 1'b1; spr_k = 0; cpu_k = 0;
        for (int c = 0; c < 13; c++) begin
            bus.slot    = 3'(c % 8);
            bus.bg_a    = 14'h0300 + 14'(c);
            bus.cpu_req = (c == 0);
            bus.spr_req = spr_hold;
            tick();
            if (bus.spr_ack) spr_k++;
            if (bus.cpu_ack) cpu_k++;
            if (c == 2) begin
                chk("mix_spr_addr", bus.vram_a, 14'h2000);
                chk("mix_spr_we", bus.vram_we, 0);
            end
            if (c == 3) begin
                chk("mix_spr_ack", bus.spr_ack, 1);
                chk("mix_spr_data", bus.vram_d, mdl(14'h2000));
            end
            if (c == 7) begin
                chk("mix_cpu_addr", bus.vram_a, 14'h0ABC);
                chk("mix_cpu_we", bus.vram_we, 0);
            end
            if (c == 8) chk("mix_cpu_ack", bus.cpu_ack, 1);
            if (c == 9) begin
                chk("mix_cpu_rd", bus.cpu_rd, mdl(14'h0ABC));
                chk("mix_busy_done", bus.cpu_busy, 0);
            end
            if (bus.spr_ack) spr_hold = 1'b0;
        end
        chk("mix_spr_ack_count", spr_k, 1);
        chk("mix_cpu_ack_count", cpu_k, 1);

        // Reset while a CPU write is pending: nothing may complete afterwards.
        bus.active = 1'b1; bus.slot = 3'd3; bus.bg_a = 14'h0500;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 14'h1111; bus.cpu_wd = 8'h77;
        tick();
        chk("rst_pend_busy", bus.cpu_busy, 1);
        bus.cpu_req = 1'b0; bus.slot = 3'd4;
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.slot = 3'((5 + i) % 8);
            tick();
            chk("rst_no_ack", bus.cpu_ack, 0);
            chk("rst_no_we", bus.vram_we, 0);
        end

        // Blanking round-robin: sprite held high against four CPU reads.
        do_reset();
        bus.active = 1'b0; bus.bg_a = 14'h3F00; bus.spr_a = 14'h2000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 14'h0400;
        exp_g[0] = 14'h0400; exp_g[1] = 14'h2000; exp_g[2] = 14'h0401; exp_g[3] = 14'h2000;
        exp_g[4] = 14'h0402; exp_g[5] = 14'h2000; exp_g[6] = 14'h0403;
        n = 0; ng = 0; spr_g = 0; spr_k = 0; cyc = 0;
        prev_ack = 1'b0; prev_spr_ack = 1'b0;
        while (!(n == 4 && !prev_ack) && cyc < 60) begin
            tick();
            cyc++;
            if (bus.vram_a != 14'h3F00) begin
                if (ng < 7) chk($sformatf("rr_grant%0d", ng), bus.vram_a, exp_g[ng]);
                ng++;
                if (bus.vram_a == 14'h2000) spr_g++;
            end
            if (bus.spr_ack) begin
                spr_k++;
                chk("rr_spr_ack_single", prev_spr_ack, 0);
                chk("rr_spr_ack_le_grants", (spr_k <= spr_g), 1);
            end
            if (prev_ack) chk($sformatf("rr_cpu_rd%0d", n), bus.cpu_rd, mdl(14'h0400 + 14'(n - 1)));
            prev_ack = bus.cpu_ack;
            prev_spr_ack = bus.spr_ack;
            if (bus.cpu_ack) begin
                n++;
                if (n < 4) bus.cpu_a = 14'h0400 + 14'(n);
                else bus.cpu_req = 1'b0;
            end
            bus.spr_req = 1'b1;
        end
        chk("rr_cpu_ack_count", n, 4);
        chk("rr_grant_count", (ng >= 7), 1);
        bus.spr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.spr_ack) spr_k++;
        end
        chk("rr_spr_ack_total", spr_k, spr_g);

        // Back-to-back CPU writes: new request taken in the ack cycle.
        do_reset();
        bus.active = 1'b0; bus.bg_a = 14'h3F00;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 14'h0AAA; bus.cpu_wd = 8'h11;
        tick();
        chk("b2b_busy_pend", bus.cpu_busy, 1);
        bus.cpu_req = 1'b0;
        tick();
        chk("b2b_a1", bus.vram_a, 14'h0AAA);
        chk("b2b_we1", bus.vram_we, 1);
        chk("b2b_wd1", bus.vram_wd, 8'h11);
        tick();
        chk("b2b_ack1", bus.cpu_ack, 1);
        chk("b2b_busy_ack", bus.cpu_busy, 1);
        bus.cpu_req = 1'b1; bus.cpu_a = 14'h0BBB; bus.cpu_wd = 8'h22;
        tick();
        chk("b2b_busy_second", bus.cpu_busy, 1);
        chk("b2b_ack_gap", bus.cpu_ack, 0);
        bus.cpu_req = 1'b0;
        tick();
        chk("b2b_a2", bus.vram_a, 14'h0BBB);
        chk("b2b_we2", bus.vram_we, 1);
        chk("b2b_wd2", bus.vram_wd, 8'h22);
        tick();
        chk("b2b_ack2", bus.cpu_ack, 1);
        tick();
        chk("b2b_busy_idle", bus.cpu_busy, 0);
        chk("b2b_ack_end", bus.cpu_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
